// File: rtl/traffic_phase_timer_pkg.sv
// Shared types for the traffic-light pacing logic: phase and FSM encodings plus the
// lamp decoder, which the sequencer's checker reuses.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_RA = 2'd1,
        PH_G  = 2'd2,
        PH_A  = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    typedef struct packed {
        logic   legal;
        phase_e phase;
    } lamp_dec_t;

    // Only the four UK lamp patterns are legal; anything else is reported as illegal.
    function automatic lamp_dec_t lamp_decode(input logic red, input logic amber, input logic green);
        lamp_dec_t d;
        d.legal = 1'b1;
        d.phase = PH_R;
        case ({red, amber, green})
            3'b100:  d.phase = PH_R;
            3'b110:  d.phase = PH_RA;
            3'b001:  d.phase = PH_G;
            3'b010:  d.phase = PH_A;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the lamp sequencer side (master) and the phase timer (slave).
interface traffic_phase_timer_if
    import traffic_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             tick_en;
    logic             red;
    logic             amber;
    logic             green;
    logic             ped_req;
    logic             advance;
    logic             ped_wait;
    phase_e           phase;
    logic [CNT_W-1:0] remaining;
    logic             fault;

    modport master (
        output tick_en, red, amber, green, ped_req,
        input  advance, ped_wait, phase, remaining, fault
    );

    modport slave (
        input  tick_en, red, amber, green, ped_req,
        output advance, ped_wait, phase, remaining, fault
    );
endinterface

// File: rtl/traffic_phase_timer_dwell_counter.sv
// Loadable down-counter holding the ticks left in the current phase; saturates at zero.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
endmodule

// File: rtl/traffic_phase_timer.sv
// Pacing stage for the red/amber/green sequencer: times each lamp phase, strobes advance on
// expiry, truncates green for a waiting pedestrian and latches a sticky fault.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int RED_TICKS       = 8,
    parameter int RED_AMBER_TICKS = 2,
    parameter int GREEN_TICKS     = 10,
    parameter int AMBER_TICKS     = 3,
    parameter int MIN_GREEN_TICKS = 4,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_timer_if.slave bus
);
    localparam logic [CNT_W-1:0] TRUNC_THRESH = CNT_W'(GREEN_TICKS - MIN_GREEN_TICKS);

    if (RED_TICKS < 1 || RED_AMBER_TICKS < 1 || GREEN_TICKS < 1 ||
        AMBER_TICKS < 1 || MIN_GREEN_TICKS < 1) begin : g_bad_min
        $error("traffic_phase_timer: every *_TICKS parameter must be at least 1");
    end
    if (MIN_GREEN_TICKS > GREEN_TICKS) begin : g_bad_green
        $error("traffic_phase_timer: MIN_GREEN_TICKS must not exceed GREEN_TICKS");
    end
    if (RED_TICKS >= (1 << CNT_W) || RED_AMBER_TICKS >= (1 << CNT_W) ||
        GREEN_TICKS >= (1 << CNT_W) || AMBER_TICKS >= (1 << CNT_W) ||
        MIN_GREEN_TICKS >= (1 << CNT_W)) begin : g_bad_width
        $error("traffic_phase_timer: *_TICKS parameters must fit in CNT_W bits");
    end

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic             advance_q, advance_d;
    logic             fault_q, fault_d;
    logic             pedWait_q, pedWait_d;
    logic             wdog_q, wdog_d;
    logic             cntLoad, cntDec, cntZero, expire;
    logic [CNT_W-1:0] cntVal, loadVal;
    lamp_dec_t        lampDec;

    function automatic logic [CNT_W-1:0] dwellLoad(input phase_e p);
        logic [CNT_W-1:0] v;
        case (p)
            PH_R:    v = CNT_W'(RED_TICKS - 1);
            PH_RA:   v = CNT_W'(RED_AMBER_TICKS - 1);
            PH_G:    v = CNT_W'(GREEN_TICKS - 1);
            default: v = CNT_W'(AMBER_TICKS - 1);
        endcase
        return v;
    endfunction

    assign lampDec = lamp_decode(bus.red, bus.amber, bus.green);

    // A waiting pedestrian turns any tick past the minimum green into an expiry.
    assign expire = bus.tick_en &&
                    (cntZero || (phase_q == PH_G && pedWait_q && cntVal <= TRUNC_THRESH));

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .loadVal_i (loadVal),
        .load_i    (cntLoad),
        .dec_i     (cntDec),
        .count_o   (cntVal),
        .zero_o    (cntZero)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        advance_d = 1'b0;
        fault_d   = fault_q;
        wdog_d    = wdog_q;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        loadVal   = dwellLoad(lampDec.phase);
        if (state_q != ST_FAULT && !lampDec.legal) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    cntLoad = 1'b1;
                    phase_d = lampDec.phase;
                    wdog_d  = 1'b0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (expire) begin
                        advance_d = 1'b1;
                        wdog_d    = 1'b0;
                        state_d   = ST_WAIT;
                    end else if (bus.tick_en) begin
                        cntDec = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // The tick coinciding with advance is deliberately not counted.
                    if (lampDec.phase != phase_q) begin
                        cntLoad = 1'b1;
                        phase_d = lampDec.phase;
                        wdog_d  = 1'b0;
                        state_d = ST_RUN;
                    end else if (bus.tick_en && !advance_q) begin
                        if (wdog_q) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            wdog_d = 1'b1;
                        end
                    end
                end
                default: fault_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        pedWait_d = pedWait_q;
        if (bus.ped_req && lampDec.legal && lampDec.phase != PH_R) begin
            pedWait_d = 1'b1;
        end
        if (cntLoad && phase_d == PH_R) begin
            pedWait_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SYNC;
            phase_q   <= PH_R;
            advance_q <= 1'b0;
            fault_q   <= 1'b0;
            pedWait_q <= 1'b0;
            wdog_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            advance_q <= advance_d;
            fault_q   <= fault_d;
            pedWait_q <= pedWait_d;
            wdog_q    <= wdog_d;
        end
    end

    assign bus.advance   = advance_q;
    assign bus.ped_wait  = pedWait_q;
    assign bus.phase     = phase_q;
    assign bus.remaining = cntVal;
    assign bus.fault     = fault_q;
endmodule
